// File: rtl/mux_pkg.sv
// Shared defaults and helpers for the pipelined N:1 multiplexer.
package mux_pkg;

  localparam int unsigned DefWidth = 4;
  localparam int unsigned DefN     = 8;

  // Number of tree levels needed to reduce n channels to one.
  function automatic int unsigned log2_ceil(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_2_1_reg.sv
// One registered 2:1 select node of the mux tree; carries valid and the remaining sel bits.
module mux_2_1_reg #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned SEL_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_en,
  input  logic                 i_valid,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  input  logic [SEL_WIDTH-1:0] i_sel,
  output logic                 o_valid,
  output logic [WIDTH-1:0]     o_data,
  output logic [SEL_WIDTH-1:0] o_sel
);

  logic                 r_valid;
  logic [WIDTH-1:0]     r_data;
  logic [SEL_WIDTH-1:0] r_sel;

  // Payload only loads for valid samples so the output keeps the last real result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sel   <= '0;
    end else if (i_en) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= i_sel[0] ? i_b : i_a;
        r_sel  <= i_sel >> 1;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_sel   = r_sel;

endmodule

// File: rtl/mux_n_1_pipe.sv
// Pipelined N:1 multiplexer: a balanced tree of registered 2:1 nodes, one stage per sel bit.
module mux_n_1_pipe
  import mux_pkg::*;
#(
  parameter int unsigned  WIDTH  = DefWidth,
  parameter int unsigned  N      = DefN,
  localparam int unsigned LEVELS = log2_ceil(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*WIDTH-1:0]   d,
  input  logic [LEVELS-1:0]    sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     y
);

  logic              w_advance;
  logic [WIDTH-1:0]  w_data  [LEVELS+1][N];
  logic              w_valid [LEVELS+1][N];
  logic [LEVELS-1:0] w_sel   [LEVELS+1][N];

  assign w_advance = !out_valid || out_ready;
  assign in_ready  = w_advance;

  for (genvar j = 0; j < N; j++) begin : g_in
    assign w_data[0][j]  = d[j*WIDTH +: WIDTH];
    assign w_valid[0][j] = in_valid;
    assign w_sel[0][j]   = sel;
  end

  // Level k holds N >> (k+1) nodes; unused array slots are tied off.
  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    for (genvar j = 0; j < N; j++) begin : g_node
      if (j < (N >> (k + 1))) begin : g_mux
        mux_2_1_reg #(
          .WIDTH     (WIDTH),
          .SEL_WIDTH (LEVELS)
        ) u_mux (
          .clk     (clk),
          .rst     (rst),
          .i_en    (w_advance),
          .i_valid (w_valid[k][2*j]),
          .i_a     (w_data[k][2*j]),
          .i_b     (w_data[k][2*j+1]),
          .i_sel   (w_sel[k][2*j]),
          .o_valid (w_valid[k+1][j]),
          .o_data  (w_data[k+1][j]),
          .o_sel   (w_sel[k+1][j])
        );
      end else begin : g_tie
        assign w_valid[k+1][j] = 1'b0;
        assign w_data[k+1][j]  = '0;
        assign w_sel[k+1][j]   = '0;
      end
    end
  end

  assign out_valid = w_valid[LEVELS][0];
  assign y         = w_data[LEVELS][0];

endmodule

// File: tb/tb_mux_n_1_pipe.sv
// Self-checking bench for mux_n_1_pipe: directed scenarios plus a randomized scoreboard run.
module tb_mux_n_1_pipe;

  localparam int unsigned WIDTH  = 4;
  localparam int unsigned N      = 8;
  localparam int unsigned LEVELS = 3;
  localparam logic [N*WIDTH-1:0] Ramp = 32'h7654_3210;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [N*WIDTH-1:0]   d;
  logic [LEVELS-1:0]    sel;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     y;

  int n_tests = 0;
  int n_fail  = 0;

  mux_n_1_pipe #(
    .WIDTH (WIDTH),
    .N     (N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d         (d),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] chan(input logic [N*WIDTH-1:0] dd, input int unsigned i);
    logic [N*WIDTH-1:0] s;
    s = (dd >> (i * WIDTH)) & 32'hF;
    return s[WIDTH-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    sel       = '0;
    out_ready = 1'b1;
    repeat (6) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; sel = '0; d = '0; out_ready = 1'b1;
    repeat (2) tick();
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_tests++;
    if (y !== 4'd0) begin n_fail++; $display("FAIL reset_y: got %0d want 0", y); end
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    rst = 1'b0;
    tick();
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: got %b want 0", out_valid); end
  endtask

  task automatic test_single();
    logic exp_v;
    d = Ramp; sel = 3'd5; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; sel = '0;
    for (int c = 1; c <= 4; c++) begin
      exp_v = (c == 3);
      n_tests++;
      if (out_valid !== exp_v) begin
        n_fail++; $display("FAIL single_valid_c%0d: got %b want %b", c, out_valid, exp_v);
      end
      if (c >= 3) begin
        n_tests++;
        if (y !== 4'd5) begin n_fail++; $display("FAIL single_y_c%0d: got %0d want 5", c, y); end
      end
      if (c < 4) tick();
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic             exp_v;
    logic [WIDTH-1:0] exp_y;
    d = Ramp; out_ready = 1'b1;
    for (int c = 0; c <= 11; c++) begin
      if (c > 0) begin
        exp_v = (c >= 3) && (c <= 10);
        n_tests++;
        if (out_valid !== exp_v) begin
          n_fail++; $display("FAIL b2b_valid_c%0d: got %b want %b", c, out_valid, exp_v);
        end
        if (exp_v) begin
          exp_y = chan(d, c - 3);
          n_tests++;
          if (y !== exp_y) begin n_fail++; $display("FAIL b2b_y_c%0d: got %0d want %0d", c, y, exp_y); end
        end
      end
      if (c < 8) begin in_valid = 1'b1; sel = 3'(c); end
      else in_valid = 1'b0;
      tick();
    end
    drain();
  endtask

  task automatic test_stall();
    d = Ramp; out_ready = 1'b1; in_valid = 1'b1;
    sel = 3'd1; tick();
    sel = 3'd2; tick();
    sel = 3'd3; tick();
    in_valid = 1'b0; sel = '0;
    n_tests++;
    if (out_valid !== 1'b1 || y !== 4'd1) begin
      n_fail++; $display("FAIL stall_first: valid=%b y=%0d want valid=1 y=1", out_valid, y);
    end
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_tests++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready_%0d: got %b want 0", i, in_ready); end
      n_tests++;
      if (out_valid !== 1'b1 || y !== 4'd1) begin
        n_fail++; $display("FAIL stall_hold_%0d: valid=%b y=%0d want valid=1 y=1", i, out_valid, y);
      end
      tick();
    end
    n_tests++;
    if (out_valid !== 1'b1 || y !== 4'd1) begin
      n_fail++; $display("FAIL stall_end_hold: valid=%b y=%0d want valid=1 y=1", out_valid, y);
    end
    out_ready = 1'b1;
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || y !== 4'd2) begin
      n_fail++; $display("FAIL stall_release_2: valid=%b y=%0d want valid=1 y=2", out_valid, y);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || y !== 4'd3) begin
      n_fail++; $display("FAIL stall_release_3: valid=%b y=%0d want valid=1 y=3", out_valid, y);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_empty: got %b want 0", out_valid); end
    drain();
  endtask

  task automatic test_bubble();
    d = Ramp; out_ready = 1'b1;
    in_valid = 1'b1; sel = 3'd6; tick();
    in_valid = 1'b0; sel = 3'd1; tick();
    in_valid = 1'b1; sel = 3'd3; tick();
    in_valid = 1'b0; sel = '0;
    n_tests++;
    if (out_valid !== 1'b1 || y !== 4'd6) begin
      n_fail++; $display("FAIL bubble_first: valid=%b y=%0d want valid=1 y=6", out_valid, y);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b0 || y !== 4'd6) begin
      n_fail++; $display("FAIL bubble_gap: valid=%b y=%0d want valid=0 y=6", out_valid, y);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || y !== 4'd3) begin
      n_fail++; $display("FAIL bubble_second: valid=%b y=%0d want valid=1 y=3", out_valid, y);
    end
    drain();
  endtask

  task automatic test_sel_capture();
    logic [N*WIDTH-1:0] d2;
    logic [WIDTH-1:0]   exp2;
    d2   = 32'hFEDC_BA98;
    exp2 = chan(d2, 2);
    out_ready = 1'b1;
    d = Ramp; sel = 3'd7; in_valid = 1'b1; tick();
    d = d2;   sel = 3'd2; tick();
    in_valid = 1'b0; sel = 3'd0; d = '0;
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || y !== 4'd7) begin
      n_fail++; $display("FAIL capture_first: valid=%b y=%0d want valid=1 y=7", out_valid, y);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b1 || y !== exp2) begin
      n_fail++; $display("FAIL capture_second: valid=%b y=%0d want valid=1 y=%0d", out_valid, y, exp2);
    end
    drain();
  endtask

  task automatic test_reset_midflight();
    d = Ramp; out_ready = 1'b1; in_valid = 1'b1;
    sel = 3'd1; tick();
    sel = 3'd2; tick();
    sel = 3'd4; tick();
    in_valid = 1'b0; sel = '0;
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || y !== 4'd0) begin
      n_fail++; $display("FAIL midreset_async: valid=%b y=%0d want valid=0 y=0", out_valid, y);
    end
    tick();
    rst = 1'b0;
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_ready: got %b want 1", in_ready); end
    for (int i = 0; i < 6; i++) begin
      tick();
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL midreset_stale_%0d: valid=%b y=%0d want valid=0", i, out_valid, y);
      end
    end
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] q[$];
    logic             prev_stall;
    logic [WIDTH-1:0] prev_y;
    logic             exp_ready;
    logic [WIDTH-1:0] exp_y;
    prev_stall = 1'b0;
    prev_y     = '0;
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      sel       = 3'($urandom_range(0, 7));
      d         = $urandom;
      out_ready = ($urandom_range(0, 9) < 6);
      #1;
      if (prev_stall) begin
        n_tests++;
        if (out_valid !== 1'b1 || y !== prev_y) begin
          n_fail++; $display("FAIL rand_stall_c%0d: valid=%b y=%0d want valid=1 y=%0d", c, out_valid, y, prev_y);
        end
      end
      exp_ready = !out_valid || out_ready;
      n_tests++;
      if (in_ready !== exp_ready) begin
        n_fail++; $display("FAIL rand_ready_c%0d: got %b want %b", c, in_ready, exp_ready);
      end
      if (out_valid && out_ready) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL rand_spurious_c%0d: output y=%0d with nothing pending", c, y);
        end else begin
          exp_y = q.pop_front();
          if (y !== exp_y) begin
            n_fail++; $display("FAIL rand_data_c%0d: got %0d want %0d", c, y, exp_y);
          end
        end
      end
      if (in_valid && exp_ready) q.push_back(chan(d, sel));
      prev_stall = out_valid && !out_ready;
      prev_y     = y;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (out_valid) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL rand_drain_spurious: output y=%0d with nothing pending", y);
        end else begin
          exp_y = q.pop_front();
          if (y !== exp_y) begin n_fail++; $display("FAIL rand_drain_data: got %0d want %0d", y, exp_y); end
        end
      end
      tick();
    end
    n_tests++;
    if (q.size() != 0) begin
      n_fail++; $display("FAIL rand_dropped: %0d samples never emerged, want 0", q.size());
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; sel = '0; d = '0; out_ready = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_bubble();
    test_sel_capture();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_n_1_pipe.md
MUX_N_1_PIPE -- requirements
Module: mux_n_1_pipe

Interface
REQ-001 Parameter WIDTH, default 4, data bits per input channel.
REQ-002 Parameter N, default 8, number of input channels; power of two, N >= 2.
REQ-003 Derived constant LEVELS = log2(N), number of pipeline levels.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 in_valid  input  1  d/sel hold a sample to accept.
REQ-008 in_ready  output  1  block accepts a sample this cycle.
REQ-009 d  input  N*WIDTH  channel i in bits [i*WIDTH +: WIDTH].
REQ-010 sel  input  LEVELS  channel index to forward.
REQ-011 out_valid  output  1  y holds a result.
REQ-012 out_ready  input  1  consumer accepts y this cycle.
REQ-013 y  output  WIDTH  selected channel data.

Function
REQ-014 Balanced binary tree of 2:1 selections with one register stage per level; level k (k = 0 first) SHALL select with sel bit k, pairs (2j, 2j+1), lower index on bit = 0.
REQ-015 Each level SHALL carry the unused upper sel bits and a valid bit alongside its data.
REQ-016 advance = !out_valid || out_ready; in_ready SHALL equal advance, combinationally.
REQ-017 A sample is accepted on a rising edge with in_valid && in_ready.
REQ-018 On advance, every level SHALL shift one stage; when advance = 0 all stages, out_valid and y SHALL hold.
REQ-019 A stage's data register SHALL load only when advance = 1 and the incoming valid bit = 1; its valid bit loads on every advance.
REQ-020 Latency: y/out_valid SHALL reflect an accepted sample exactly LEVELS cycles after acceptance when out_ready stays high.
REQ-021 Throughput: one sample per cycle with out_ready held high; samples emerge in acceptance order, none dropped or duplicated.
REQ-022 Bubbles (in_valid = 0 on advance) SHALL propagate as out_valid = 0; y SHALL keep the last valid result.
REQ-023 Stall with out_valid = 1 and out_ready = 0 SHALL keep y and out_valid stable until out_ready = 1.
REQ-024 The sel value for each sample SHALL be captured at acceptance; later sel changes SHALL not affect it.

Reset
REQ-025 While rst = 1, all valid bits, out_valid and all data/sel registers SHALL clear to 0 immediately; y = 0.
REQ-026 Reset mid-operation SHALL discard all in-flight samples; in_ready = 1 from the first cycle after deassertion.

Structure
REQ-027 A shared package mux_pkg SHALL hold default WIDTH/N constants and a log2 helper for LEVELS.
REQ-028 One sub-module mux_2_1_reg (registered 2:1 select with valid and enable) SHALL be instantiated N-1 times via generate.

Verification (N = 8, WIDTH = 4, LEVELS = 3)
REQ-029 d = {7,6,5,4,3,2,1,0} channels, sel = 5, one accepted sample, out_ready = 1 -> out_valid = 1 with y = 5 exactly 3 cycles later, then out_valid = 0.
REQ-030 Back-to-back sel = 0..7 each cycle, out_ready = 1 -> y = 0..7 on 8 consecutive cycles starting cycle 3.
REQ-031 Stream sel = 1,2,3; out_ready = 0 when y = 1 first valid for 4 cycles -> in_ready = 0, y = 1 held; after release y = 2, 3 on consecutive cycles.
REQ-032 Alternate in_valid 1/0 with sel = 6 then 3 -> out_valid pattern 1,0,1; y = 6 held through bubble, then 3.
REQ-033 Accept sel = 7, change sel and d next cycle -> y = original channel 7 value.
REQ-034 rst pulse with 3 samples in flight -> out_valid = 0, y = 0 same cycle; no stale sample ever appears after reset.
